// File: rtl/alu4_pkg.sv
// Shared definitions for the 4-bit ALU result path.
//   ALU_W            : ALU data width
//   RES_LSB..SF_BIT  : bit offsets of the fields inside a stored entry
//   alu4_entry_t     : packed entry {sf, cf, zf, result}
//   DROP_MAX         : saturation value of the dropped-result counter
package alu4_pkg;

  localparam int ALU_W   = 4;

  localparam int RES_LSB = 0;
  localparam int ZF_BIT  = ALU_W;
  localparam int CF_BIT  = ALU_W + 1;
  localparam int SF_BIT  = ALU_W + 2;

  typedef struct packed {
    logic             sf;
    logic             cf;
    logic             zf;
    logic [ALU_W-1:0] result;
  } alu4_entry_t;

  localparam int DROP_MAX = 255;

endpackage

// File: rtl/alu4_fifo_mem.sv
// Register-array storage for the ALU result FIFO.
//   clk   : write clock
//   we    : write enable, entry written at waddr on the rising edge
//   waddr : write index (parent's write pointer)
//   wdata : entry to store
//   raddr : read index (parent's read pointer)
//   rdata : entry at raddr, combinational
// The array is deliberately not reset; the parent's count decides which
// slots hold live data.
module alu4_fifo_mem
  import alu4_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int EW    = ALU_W + 3
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [EW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [EW-1:0]            rdata
);

  logic [EW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/alu4_result_fifo.sv
// First-word-fall-through FIFO capturing ALU results and flags.
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid/in_ready     : producer handshake; in_ready = not full
//   in_result, in_zf/cf/sf: ALU result and flags to capture
//   out_valid/out_ready   : consumer handshake; out_valid = not empty
//   out_result, out_zf/cf/sf : head entry, forced to 0 while empty
//   count                 : occupancy 0..DEPTH
//   sticky_cf/sticky_zf   : OR of flags of accepted entries, clr_sticky clears
//   drop_cnt              : saturating count of cycles offered while full
module alu4_result_fifo
  import alu4_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = ALU_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [W-1:0]             in_result,
  input  logic                     in_zf,
  input  logic                     in_cf,
  input  logic                     in_sf,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_result,
  output logic                     out_zf,
  output logic                     out_cf,
  output logic                     out_sf,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     sticky_cf,
  output logic                     sticky_zf,
  input  logic                     clr_sticky,
  output logic [7:0]               drop_cnt
);

  localparam int PW     = $clog2(DEPTH);
  localparam int CW     = PW + 1;
  localparam int EW     = W + 3;
  localparam int ZF_OFF = RES_LSB + W;
  localparam int CF_OFF = RES_LSB + W + 1;
  localparam int SF_OFF = RES_LSB + W + 2;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'(DROP_MAX)) ? v : v + 8'd1;
  endfunction

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          sticky_cf_q, sticky_cf_d;
  logic          sticky_zf_q, sticky_zf_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;

  logic          push, pop, drop;
  logic [EW-1:0] wr_entry, head_entry;

  // Handshake flags come only from registered count, never from in_valid/out_ready.
  assign in_ready  = (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;
  assign drop = in_valid && !in_ready;

  assign wr_entry = {in_sf, in_cf, in_zf, in_result};

  alu4_fifo_mem #(
    .DEPTH (DEPTH),
    .EW    (EW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (head_entry)
  );

  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d     = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    // A set from an accepted push overrides a same-cycle clear.
    sticky_cf_d = (sticky_cf_q && !clr_sticky) || (push && in_cf);
    sticky_zf_d = (sticky_zf_q && !clr_sticky) || (push && in_zf);
    drop_cnt_d  = drop ? sat_inc(drop_cnt_q) : drop_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      sticky_cf_q <= 1'b0;
      sticky_zf_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      sticky_cf_q <= sticky_cf_d;
      sticky_zf_q <= sticky_zf_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Head is masked to zero while empty so stale array contents never leak.
  assign out_result = out_valid ? head_entry[RES_LSB +: W] : '0;
  assign out_zf     = out_valid && head_entry[ZF_OFF];
  assign out_cf     = out_valid && head_entry[CF_OFF];
  assign out_sf     = out_valid && head_entry[SF_OFF];

  assign count     = count_q;
  assign sticky_cf = sticky_cf_q;
  assign sticky_zf = sticky_zf_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_alu4_result_fifo.sv
module tb_alu4_result_fifo;
  import alu4_pkg::*;

  localparam int DEPTH = 4;
  localparam int W     = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_result;
  logic         in_zf, in_cf, in_sf;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_zf, out_cf, out_sf;
  logic [2:0]   count;
  logic         sticky_cf, sticky_zf;
  logic         clr_sticky;
  logic [7:0]   drop_cnt;

  always #5 clk = ~clk;

  alu4_result_fifo #(.DEPTH(DEPTH), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_result  (in_result),
    .in_zf      (in_zf),
    .in_cf      (in_cf),
    .in_sf      (in_sf),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zf     (out_zf),
    .out_cf     (out_cf),
    .out_sf     (out_sf),
    .count      (count),
    .sticky_cf  (sticky_cf),
    .sticky_zf  (sticky_zf),
    .clr_sticky (clr_sticky),
    .drop_cnt   (drop_cnt)
  );

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  // Reference model: a queue of entries plus sticky bits and drop count.
  alu4_entry_t mq[$];
  bit          m_scf, m_szf;
  int          m_drop;

  function automatic void chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_scf  = 1'b0;
    m_szf  = 1'b0;
    m_drop = 0;
  endfunction

  // Applied once per rising edge with the inputs that were present at it.
  function automatic void model_step();
    alu4_entry_t e;
    bit full, empty, do_push, do_pop;
    if (rst) begin
      model_reset();
      return;
    end
    full    = (mq.size() == DEPTH);
    empty   = (mq.size() == 0);
    do_push = in_valid && !full;
    do_pop  = out_ready && !empty;
    if (do_pop) void'(mq.pop_front());
    if (do_push) begin
      e.sf = in_sf; e.cf = in_cf; e.zf = in_zf; e.result = in_result;
      mq.push_back(e);
    end
    m_scf = (m_scf && !clr_sticky) || (do_push && in_cf);
    m_szf = (m_szf && !clr_sticky) || (do_push && in_zf);
    if (in_valid && full && m_drop < 255) m_drop++;
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      alu4_entry_t h;
      h = (mq.size() != 0) ? mq[0] : '0;
      chk("count",      int'(count),      mq.size());
      chk("out_valid",  int'(out_valid),  int'(mq.size() != 0));
      chk("in_ready",   int'(in_ready),   int'(mq.size() < DEPTH));
      chk("out_result", int'(out_result), int'(h.result));
      chk("out_zf",     int'(out_zf),     int'(h.zf));
      chk("out_cf",     int'(out_cf),     int'(h.cf));
      chk("out_sf",     int'(out_sf),     int'(h.sf));
      chk("sticky_cf",  int'(sticky_cf),  int'(m_scf));
      chk("sticky_zf",  int'(sticky_zf),  int'(m_szf));
      chk("drop_cnt",   int'(drop_cnt),   m_drop);
    end
  end

  task automatic cyc(input bit v, input int res, input bit zf, input bit cf,
                     input bit sf, input bit ordy, input bit clr);
    in_valid   = v;
    in_result  = res[W-1:0];
    in_zf      = zf;
    in_cf      = cf;
    in_sf      = sf;
    out_ready  = ordy;
    clr_sticky = clr;
    @(posedge clk);
    model_step();
    #1;
  endtask

  int exp_ord[4] = '{3, 12, 5, 0};

  initial begin
    rst = 1'b1;
    in_valid = 0; in_result = '0; in_zf = 0; in_cf = 0; in_sf = 0;
    out_ready = 0; clr_sticky = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset / idle state
    chk("rst_count",     int'(count),      0);
    chk("rst_out_valid", int'(out_valid),  0);
    chk("rst_in_ready",  int'(in_ready),   1);
    chk("rst_out_result",int'(out_result), 0);
    chk("rst_drop",      int'(drop_cnt),   0);
    chk("rst_sticky",    int'({sticky_cf, sticky_zf}), 0);
    check_en = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Single push of 15 with sf=1, then pop
    cyc(1, 15, 0, 0, 1, 0, 0);
    chk("push15_valid",  int'(out_valid),  1);
    chk("push15_result", int'(out_result), 15);
    chk("push15_sf",     int'(out_sf),     1);
    chk("push15_count",  int'(count),      1);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("pop15_count",   int'(count),      0);
    chk("pop15_valid",   int'(out_valid),  0);

    // Fill with 3,12,5,0 (last has zf=cf=1)
    for (int i = 0; i < 4; i++)
      cyc(1, exp_ord[i], i == 3, i == 3, 0, 0, 0);
    chk("fill_in_ready", int'(in_ready),  0);
    chk("fill_count",    int'(count),     4);
    chk("fill_scf",      int'(sticky_cf), 1);
    chk("fill_szf",      int'(sticky_zf), 1);
    for (int i = 0; i < 4; i++) begin
      chk("pop_order", int'(out_result), exp_ord[i]);
      cyc(0, 0, 0, 0, 0, 1, 0);
    end

    // Second fill across the pointer wrap, then drain
    for (int i = 0; i < 4; i++) cyc(1, $urandom_range(15), 0, 0, $urandom_range(1), 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 1, 0);

    // Full hold: drops saturate, dropped cf=1 entries leave sticky alone
    for (int i = 0; i < 4; i++) cyc(1, i + 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 260; i++) cyc(1, 9, 1, 1, 0, 0, 0);
    chk("sat_drop",   int'(drop_cnt),   255);
    chk("sat_scf",    int'(sticky_cf),  0);
    chk("sat_szf",    int'(sticky_zf),  0);
    chk("sat_count",  int'(count),      4);
    chk("sat_head",   int'(out_result), 1);
    // Pop while full and still offering: drop still counted (saturated), no pass-through
    cyc(1, 9, 1, 1, 0, 1, 0);
    chk("fullpop_count", int'(count), 3);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1, 0);

    // Streaming at count=2
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, i + 2, 0, 0, 0, 1, 0);
    chk("stream_count", int'(count),      2);
    chk("stream_head",  int'(out_result), 10);
    cyc(1, 5, 0, 1, 0, 0, 1);
    chk("clrset_scf",   int'(sticky_cf),  1);
    chk("clrset_szf",   int'(sticky_zf),  0);
    chk("clrset_count", int'(count),      3);

    // Asynchronous reset mid-stream at count=3
    check_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_count",     int'(count),      0);
    chk("arst_out_valid", int'(out_valid),  0);
    chk("arst_in_ready",  int'(in_ready),   1);
    chk("arst_out_result",int'(out_result), 0);
    chk("arst_scf",       int'(sticky_cf),  0);
    chk("arst_drop",      int'(drop_cnt),   0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    check_en = 1'b1;
    cyc(1, 7, 0, 0, 0, 0, 0);
    chk("post_rst_count", int'(count),      1);
    chk("post_rst_head",  int'(out_result), 7);

    // Randomized traffic
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(3) != 0, $urandom_range(15), $urandom_range(1),
          $urandom_range(1), $urandom_range(1), $urandom_range(2) != 0,
          $urandom_range(15) == 0);
    for (int i = 0; i < DEPTH + 1; i++) cyc(0, 0, 0, 0, 0, 1, 0);
    chk("final_count", int'(count), 0);

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu4_result_fifo.md
# alu4_result_fifo

Buffering stage directly downstream of the 4-bit ALU. It captures each ALU result with its zero, carry and sign flags into a small first-word-fall-through FIFO. It presents entries to the consumer over a valid/ready handshake. It also keeps sticky carry/zero summaries and a count of results dropped while full.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥ 2
- W, 4, result width (matches ALU data width)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  ALU result and flags on in_* are valid this cycle
- in_result  in  W  ALU out
- in_zf  in  1  ALU ZF
- in_cf  in  1  ALU CF
- in_sf  in  1  ALU SF
- in_ready  out  1  FIFO not full; high when count < DEPTH
- out_valid  out  1  head entry present; high when count != 0
- out_ready  in  1  consumer accepts head this cycle
- out_result  out  W  head entry result; 0 when out_valid=0
- out_zf, out_cf, out_sf  out  1 each  head entry flags; 0 when out_valid=0
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- sticky_cf  out  1  set by any accepted entry with cf=1
- sticky_zf  out  1  set by any accepted entry with zf=1
- clr_sticky  in  1  synchronous clear of sticky_cf/sticky_zf
- drop_cnt  out  8  results offered while full; saturates at 255

## Operation
- Entry = {sf, cf, zf, result}, W+3 bits, stored unmodified.
- Push: in_valid && in_ready. Writes at wr_ptr; wr_ptr increments mod DEPTH.
- Pop: out_valid && out_ready. rd_ptr increments mod DEPTH.
- Both push and pop in the same cycle, FIFO neither empty nor full: both happen, count unchanged.
- Full, in_valid=1: in_ready=0, so no push. drop_cnt increments even if a pop occurs in the same cycle; there is no full pass-through.
- Empty, out_ready=1: no pop. With a simultaneous push, the entry is stored and count becomes 1; there is no bypass.
- count: +1 on push only, −1 on pop only, otherwise held.
- sticky_cf/sticky_zf: OR in the flags of accepted pushes only. A dropped entry does not set them.
- clr_sticky clears both sticky bits. If a set occurs in the same cycle, the set wins (bit = 1).
- drop_cnt: +1 per dropped cycle, holds at 255, cleared only by rst.
- Pointer wrap: pointers are $clog2(DEPTH) bits; full/empty are derived from count, not from pointer equality.

## Timing
- Reset (async assert, sync release on next clk edge):
  - count=0, both pointers=0
  - out_valid=0, in_ready=1, out_* data=0
  - sticky_cf=0, sticky_zf=0, drop_cnt=0
- rst mid-operation discards all entries immediately; the storage array contents need not be cleared.
- Push latency: an entry accepted at edge N drives out_* and out_valid after edge N (usable in cycle N+1).
- out_* is combinational from the head entry. It is stable while out_valid=1 and out_ready=0.
- in_ready and out_valid depend only on registered count. There is no combinational path from in_valid or out_ready.
- Sustained throughput is one push and one pop per cycle when neither empty nor full.

## Structure
- Shared package alu4_pkg holds:
  - ALU_W = 4
  - entry field offsets (RES_LSB = 0, ZF_BIT = W, CF_BIT = W+1, SF_BIT = W+2)
  - packed entry typedef alu4_entry_t
  - DROP_MAX = 255
- One sub-module, alu4_fifo_mem: DEPTH × (W+3) register array with one write port and one async read port, indexed by the parent's pointers.
- The parent owns the pointers, count, handshake, sticky and drop logic.

## Test plan
- Reset, then idle: count=0, out_valid=0, in_ready=1, out_result=0, drop_cnt=0, sticky bits 0.
- Push result 4'd15 (zf=0, cf=0, sf=1) with out_ready=0: next cycle out_valid=1, out_result=15, out_sf=1, count=1. Pop it: count=0, out_valid=0.
- Push 4'd3, 4'd12, 4'd5, 4'd0 (zf=1, cf=1 on the last) back-to-back. Then:
  - in_ready=0, count=4, sticky_cf=1, sticky_zf=1
  - popping yields 3, 12, 5, 0 in order
  - pointers wrap correctly on a second fill
- Hold full with in_valid=1 for 260 cycles: drop_cnt saturates at 255, contents unchanged, sticky bits not affected by dropped entries with cf=1.
- Simultaneous push and pop at count=2 for 10 cycles with incrementing results: count stays 2 and the output order matches the input order. Assert clr_sticky together with an accepted push with cf=1: sticky_cf=1.
- Assert rst mid-stream at count=3: outputs return to reset values asynchronously. After release, the first push emerges as the head with count=1.
